// File: rtl/sync_fifo_memory.sv
// sync_fifo_memory: single-clock FIFO over a register array `mem`.
// Ports: clk_a, rst_n (async, active-low), din_a/wen_a (write side),
//        ren_b/dout_b (read side, registered data), full, empty.
module sync_fifo_memory #(
    parameter int FIFO_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 512,
    parameter int ADDRESS_SIZE = 9
) (
    input  logic                  clk_a,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] din_a,
    input  logic                  wen_a,
    input  logic                  ren_b,
    output logic [FIFO_WIDTH-1:0] dout_b,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDRESS_SIZE:0] PTR_ONE =
        {{ADDRESS_SIZE{1'b0}}, 1'b1};

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    // MSB of each pointer is a wrap bit that tells full from empty
    logic [ADDRESS_SIZE:0] wr_ptr;
    logic [ADDRESS_SIZE:0] rd_ptr;
    logic [ADDRESS_SIZE:0] wr_ptr_d;
    logic [ADDRESS_SIZE:0] rd_ptr_d;
    logic [FIFO_WIDTH-1:0] dout_d;

    logic wr_en;
    logic rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDRESS_SIZE-1:0] == rd_ptr[ADDRESS_SIZE-1:0])
                && (wr_ptr[ADDRESS_SIZE] != rd_ptr[ADDRESS_SIZE]);

    // Requests are qualified by the flags seen before the edge
    assign wr_en = wen_a & ~full;
    assign rd_en = ren_b & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        dout_d   = dout_b;
        if (wr_en) begin
            wr_ptr_d = wr_ptr + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr + PTR_ONE;
            dout_d   = mem[rd_ptr[ADDRESS_SIZE-1:0]];
        end
    end

    // Storage is deliberately not reset; reset only empties it logically
    always_ff @(posedge clk_a) begin
        if (wr_en) begin
            mem[wr_ptr[ADDRESS_SIZE-1:0]] <= din_a;
        end
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout_b <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            dout_b <= dout_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_memory.sv
// tb_sync_fifo_memory: directed and random traffic for sync_fifo_memory,
// compared against a queue-based reference model.
module tb_sync_fifo_memory;

    localparam int W  = 16;
    localparam int D  = 512;
    localparam int AW = 9;

    logic         clk_a = 1'b0;
    logic         rst_n;
    logic [W-1:0] din_a;
    logic         wen_a;
    logic         ren_b;
    logic [W-1:0] dout_b;
    logic         full;
    logic         empty;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout;

    always #5 clk_a = ~clk_a;

    sync_fifo_memory #(
        .FIFO_WIDTH  (W),
        .FIFO_DEPTH  (D),
        .ADDRESS_SIZE(AW)
    ) dut (
        .clk_a (clk_a),
        .rst_n (rst_n),
        .din_a (din_a),
        .wen_a (wen_a),
        .ren_b (ren_b),
        .dout_b(dout_b),
        .full  (full),
        .empty (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h",
                     tag, $time, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"}, 32'(dout_b), 32'(exp_dout));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == D));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [W-1:0] d);
        bit rd_ok;
        bit wr_ok;
        wen_a = w;
        ren_b = r;
        din_a = d;
        @(posedge clk_a);
        rd_ok = r && (q.size() != 0);
        wr_ok = w && (q.size() < D);
        if (rd_ok) exp_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        #1;
        chk_all(tag);
        @(negedge clk_a);
    endtask

    task automatic rand_phase(input int cycles, input int wp,
                              input int rp);
        for (int i = 0; i < cycles; i++) begin
            step("rand",
                 ($urandom_range(99) < wp),
                 ($urandom_range(99) < rp),
                 W'($urandom));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wen_a    = 1'b0;
        ren_b    = 1'b0;
        din_a    = '0;
        exp_dout = '0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_a);
            wen_a = 1'($urandom);
            ren_b = 1'($urandom);
            din_a = W'($urandom);
            #1;
            chk_all("reset");
        end
        @(negedge clk_a);
        rst_n = 1'b1;

        // Ordering
        step("ord_w", 1'b1, 1'b0, 16'h1111);
        step("ord_w", 1'b1, 1'b0, 16'h2222);
        step("ord_w", 1'b1, 1'b0, 16'h3333);
        step("ord_r", 1'b0, 1'b1, 16'h0);
        chk("ord_r1", 32'(dout_b), 32'h1111);
        step("ord_r", 1'b0, 1'b1, 16'h0);
        chk("ord_r2", 32'(dout_b), 32'h2222);
        step("ord_r", 1'b0, 1'b1, 16'h0);
        chk("ord_r3", 32'(dout_b), 32'h3333);
        chk("ord_empty", 32'(empty), 32'd1);

        // Overflow
        for (int i = 0; i < D; i++) step("ovf_w", 1'b1, 1'b0, W'(i));
        chk("ovf_full", 32'(full), 32'd1);
        step("ovf_drop", 1'b1, 1'b0, 16'hDEAD);
        chk("ovf_still_full", 32'(full), 32'd1);
        // Full with both requests: read only
        step("full_both", 1'b1, 1'b1, 16'hBEEF);
        chk("full_both_dout", 32'(dout_b), 32'd0);
        chk("full_both_full", 32'(full), 32'd0);
        for (int i = 1; i < D; i++) begin
            step("ovf_r", 1'b0, 1'b1, 16'h0);
        end
        chk("ovf_last", 32'(dout_b), 32'(D - 1));
        chk("ovf_empty", 32'(empty), 32'd1);

        // Underflow
        for (int i = 0; i < 5; i++) step("unf", 1'b0, 1'b1, 16'h0);
        chk("unf_hold", 32'(dout_b), 32'(D - 1));
        // Empty with both requests: write only
        step("empty_both", 1'b1, 1'b1, 16'hABCD);
        chk("empty_both_dout", 32'(dout_b), 32'(D - 1));
        step("unf_r", 1'b0, 1'b1, 16'h0);
        chk("unf_rd", 32'(dout_b), 32'hABCD);

        // Wrap-around
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 300; i++) begin
                step("wrap_w", 1'b1, 1'b0, W'($urandom));
            end
            chk("wrap_300_empty", 32'(empty), 32'd0);
            chk("wrap_300_full", 32'(full), 32'd0);
            for (int i = 0; i < 300; i++) step("wrap_r", 1'b0, 1'b1, 16'h0);
            chk("wrap_0_empty", 32'(empty), 32'd1);
        end

        // Random traffic, biased to visit both full and empty
        rand_phase(200, 50, 50);
        rand_phase(700, 95, 20);
        rand_phase(100, 90, 90);
        rand_phase(800, 15, 95);
        rand_phase(200, 60, 40);

        // Reset mid-traffic: flags must clear before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_dout = '0;
        chk_all("mid_reset");
        @(negedge clk_a);
        rst_n = 1'b1;
        rand_phase(100, 70, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
